// File: rtl/tile_background_renderer.sv
// +----------------------------------------------------------------------------+
// | Module      : tile_background_renderer                                     |
// | Description : Streams a screen-sized, horizontally wrapping tilemap window  |
// |               to a pixel plotter, one pixel per cycle.                     |
// |               Optional macro BG_TRANSPARENCY_EN suppresses KEY_COLOR plots.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_background_renderer #(
  parameter int TILE_W  = 8,
  parameter int TILE_H  = 8,
  parameter int SCR_TX  = 20,
  parameter int SCR_TY  = 15,
  parameter int MAP_LEN = 100,
  parameter int CODE_W  = 2,
  parameter int COLOR_W = 9,
  parameter int LVL_AW  = 15,
  parameter int TILE_AW = 8,
  parameter int XW      = 8,
  parameter int YW      = 7
`ifdef BG_TRANSPARENCY_EN
  ,
  parameter logic [COLOR_W-1:0] KEY_COLOR = '0
`endif
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [LVL_AW-1:0]  x_offset,
  output logic               busy,
  output logic               done,
  output logic [LVL_AW-1:0]  level_addr,
  input  logic [CODE_W-1:0]  level_q,
  output logic [TILE_AW-1:0] tile_addr,
  input  logic [COLOR_W-1:0] tile_q,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [COLOR_W-1:0] color,
  output logic               plot
);

  localparam int c_pxw = $clog2(TILE_W);
  localparam int c_pyw = $clog2(TILE_H);
  localparam int c_txw = (SCR_TX > 1) ? $clog2(SCR_TX) : 1;
  localparam int c_tyw = (SCR_TY > 1) ? $clog2(SCR_TY) : 1;

  localparam logic [c_pxw-1:0] c_px_last = c_pxw'(TILE_W - 1);
  localparam logic [c_pyw-1:0] c_py_last = c_pyw'(TILE_H - 1);
  localparam logic [c_txw-1:0] c_tx_last = c_txw'(SCR_TX - 1);
  localparam logic [c_tyw-1:0] c_ty_last = c_tyw'(SCR_TY - 1);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_lvl_addr = 3'd1;
  localparam logic [2:0] c_lvl_wait = 3'd2;
  localparam logic [2:0] c_pix      = 3'd3;
  localparam logic [2:0] c_pix_last = 3'd4;
  localparam logic [2:0] c_done     = 3'd5;

  logic [2:0]         r_state;
  logic [LVL_AW-1:0]  r_off;
  logic [c_txw-1:0]   r_tx;
  logic [c_tyw-1:0]   r_ty;
  logic [c_pxw-1:0]   r_px;
  logic [c_pyw-1:0]   r_py;
  logic [CODE_W-1:0]  r_code;
  logic               r_busy;
  logic               r_done;
  logic               r_plot;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;

  logic [LVL_AW-1:0]  w_col;
  logic [LVL_AW-1:0]  w_col_wrap;
  logic [LVL_AW-1:0]  w_row_base;
  logic [TILE_AW-1:0] w_tile_addr;

  // Column wraps once at MAP_LEN; x_offset < MAP_LEN keeps off+tx below 2*MAP_LEN.
  assign w_col      = r_off + LVL_AW'(r_tx);
  assign w_col_wrap = (w_col >= LVL_AW'(MAP_LEN)) ? (w_col - LVL_AW'(MAP_LEN)) : w_col;
  assign w_row_base = LVL_AW'(r_ty) * LVL_AW'(MAP_LEN);
  assign w_tile_addr = (TILE_AW'(r_code) << (c_pxw + c_pyw))
                     | (TILE_AW'(r_py) << c_pxw)
                     | TILE_AW'(r_px);

  assign level_addr = (r_state == c_lvl_addr) ? (w_col_wrap + w_row_base) : '0;
  assign tile_addr  = (r_state == c_pix) ? w_tile_addr : '0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign x          = r_x;
  assign y          = r_y;
  // tile_q is the registered ROM output for the address issued last cycle.
  assign color      = r_plot ? tile_q : '0;

`ifdef BG_TRANSPARENCY_EN
  assign plot = r_plot && (color != KEY_COLOR);
`else
  assign plot = r_plot;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= c_idle;
      r_off   <= '0;
      r_tx    <= '0;
      r_ty    <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_code  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_plot  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_done <= 1'b0;
      r_plot <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_off   <= x_offset;
            r_tx    <= '0;
            r_ty    <= '0;
            r_busy  <= 1'b1;
            r_state <= c_lvl_addr;
          end
        end
        c_lvl_addr: r_state <= c_lvl_wait;
        c_lvl_wait: begin
          r_code  <= level_q;
          r_px    <= '0;
          r_py    <= '0;
          r_state <= c_pix;
        end
        c_pix: begin
          r_plot <= 1'b1;
          r_x    <= (XW'(r_tx) << c_pxw) + XW'(r_px);
          r_y    <= (YW'(r_ty) << c_pyw) + YW'(r_py);
          r_px   <= r_px + c_pxw'(1);
          if (r_px == c_px_last) begin
            r_px <= '0;
            if (r_py == c_py_last) r_state <= c_pix_last;
            else                   r_py    <= r_py + c_pyw'(1);
          end
        end
        c_pix_last: begin
          if (r_tx == c_tx_last) begin
            r_tx <= '0;
            if (r_ty == c_ty_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= c_done;
            end else begin
              r_ty    <= r_ty + c_tyw'(1);
              r_state <= c_lvl_addr;
            end
          end else begin
            r_tx    <= r_tx + c_txw'(1);
            r_state <= c_lvl_addr;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_background_renderer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_tile_background_renderer                                  |
// | Description : Directed self-checking bench for tile_background_renderer.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tile_background_renderer;

  localparam int FRAME_CYC = 20 * 15 * (8 * 8 + 3) + 1;
  localparam int LIMIT     = 21000;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [14:0] x_offset;
  logic        busy, done, plot;
  logic [14:0] level_addr;
  logic [1:0]  level_q;
  logic [7:0]  tile_addr;
  logic [8:0]  tile_q;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [8:0]  color;

  logic        lvl_mode;
  logic [1:0]  lvl_fill;
  logic        zero_tile0;

  int total = 0;
  int bad   = 0;

  int          cyc, nplots, pix_bad, stray;
  logic        done_seen, post_done, post_busy;
  logic [14:0] la_log [0:299];
  logic [7:0]  fx, lx;
  logic [6:0]  fy, ly;
  logic [8:0]  fc, lc;

  tile_background_renderer dut (
    .clock(clock), .resetn(resetn), .start(start), .x_offset(x_offset),
    .busy(busy), .done(done), .level_addr(level_addr), .level_q(level_q),
    .tile_addr(tile_addr), .tile_q(tile_q), .x(x), .y(y), .color(color), .plot(plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous level and tileset memories: data valid the cycle after the address.
  always @(posedge clock) begin
    level_q <= lvl_mode ? level_addr[1:0] : lvl_fill;
    tile_q  <= (zero_tile0 && tile_addr < 8'd64) ? 9'd0 : {1'b0, tile_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_code(input int off, input int tx, input int ty);
    int col;
    col = off + tx;
    if (col >= 100) col = col - 100;
    return lvl_mode ? ((col + ty * 100) % 4) : int'(lvl_fill);
  endfunction

  task automatic run_frame(input int off, input int pulse_at, input bit pulse_in_done);
    int k, q, ex, ey, ec, code;
    x_offset = 15'(off);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1; nplots = 0; pix_bad = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if ((cyc - 1) % 67 == 0 && (cyc - 1) / 67 < 300) la_log[(cyc - 1) / 67] = level_addr;
      if (plot === 1'b1) begin
        k    = nplots / 64;
        q    = nplots % 64;
        ex   = (k % 20) * 8 + q % 8;
        ey   = (k / 20) * 8 + q / 8;
        code = exp_code(off, k % 20, k / 20);
        ec   = (zero_tile0 && code == 0) ? 0 : code * 64 + q;
        if (nplots >= 19200 || int'(x) != ex || int'(y) != ey || int'(color) != ec) pix_bad++;
        if (nplots == 0) begin fx = x; fy = y; fc = color; end
        lx = x; ly = y; lc = color;
        nplots++;
      end
      start = (cyc == pulse_at);
      @(posedge clock); #1;
      cyc++;
    end
    done_seen = done;
    start = pulse_in_done;
    @(posedge clock); #1;
    start = 1'b0;
    post_done = done;
    post_busy = busy;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; x_offset = '0;
    lvl_mode = 1'b0; lvl_fill = 2'd1; zero_tile0 = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_level_addr", level_addr, 0);
    chk("rst_tile_addr", tile_addr, 0);
    resetn = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_plot", plot, 0);

    // Full frame, offset 0, every tile code 1
    run_frame(0, -1, 1'b0);
    chk("f_done_seen", done_seen, 1);
    chk("f_cycles", cyc, FRAME_CYC);
    chk("f_plots", nplots, 19200);
    chk("f_pix_bad", pix_bad, 0);
    chk("f_first_x", fx, 0);
    chk("f_first_y", fy, 0);
    chk("f_first_color", fc, 64);
    chk("f_last_x", lx, 159);
    chk("f_last_y", ly, 119);
    chk("f_last_color", lc, 127);
    chk("f_done_width", post_done, 0);
    chk("f_busy_after", post_busy, 0);

    // Horizontal wrap with offset 90, per-tile codes from level address
    lvl_mode = 1'b1;
    run_frame(90, -1, 1'b0);
    chk("w_addr_t0", la_log[0], 90);
    chk("w_addr_tx10", la_log[10], 0);
    chk("w_addr_tx19_ty2", la_log[59], 209);
    chk("w_cycles", cyc, FRAME_CYC);
    chk("w_plots", nplots, 19200);
    chk("w_pix_bad", pix_bad, 0);

    // start pulses mid-frame and in the DONE cycle are ignored
    lvl_mode = 1'b0;
    run_frame(0, 500, 1'b1);
    chk("s_cycles", cyc, FRAME_CYC);
    chk("s_plots", nplots, 19200);
    chk("s_pix_bad", pix_bad, 0);
    chk("s_busy_after_done_start", post_busy, 0);
    chk("s_done_after", post_done, 0);

    // Reset mid-frame aborts without done
    x_offset = '0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (999) @(posedge clock);
    #1;
    chk("r_busy_before", busy, 1);
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("r_busy", busy, 0);
    chk("r_plot", plot, 0);
    chk("r_done", done, 0);
    resetn = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    chk("r_quiet_after", stray, 0);
    run_frame(0, -1, 1'b0);
    chk("r_cycles", cyc, FRAME_CYC);
    chk("r_plots", nplots, 19200);

    // Level all code 0 with tile 0 all zero
    lvl_fill = 2'd0; zero_tile0 = 1'b1;
    run_frame(0, -1, 1'b0);
    chk("t_cycles", cyc, FRAME_CYC);
`ifdef BG_TRANSPARENCY_EN
    chk("t_plots", nplots, 0);
`else
    chk("t_plots", nplots, 19200);
    chk("t_pix_bad", pix_bad, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
